systolic_result_collector: RTL
==============================

// Module: systolic_result_collector
// PURPOSE
//  Read-side companion of the systolic array. Takes the column-skewed partial-sum outputs from the array's bottom edge,
//  de-skews them into complete result rows and buffers them in a FIFO. Rows leave on a valid/ready stream.
//  The array cannot stall, so the collector never back-pressures its input; it flags overflow instead.
// PARAMETERS
//  ARRAY_SIZE  4   array dimension N (rows = cols)
//  DATA_WIDTH  4   operand width; SUM_WIDTH = DATA_WIDTH*DATA_WIDTH (array's sum width)
//  FIFO_DEPTH  8   result-row FIFO entries; power of two, >= ARRAY_SIZE
// PORTS
//  clk          in   1                      single clock, rising edge
//  reset        in   1                      synchronous, active-high
//  start        in   1                      row 0 / col 0 result is on array_out this cycle
//  array_out    in   N*SUM_WIDTH            bottom-edge sums; col c at [c*SUM_WIDTH +: SUM_WIDTH], signed
//  out_row      out  N*SUM_WIDTH            aligned result row, same column packing
//  out_valid    out  1                      out_row holds a valid row
//  out_ready    in   1                      consumer accepts when out_valid && out_ready
//  out_last     out  1                      out_row is row N-1 of its batch
//  busy         out  1                      high in COLLECT
//  overflow     out  1                      sticky: an aligned row was dropped because the FIFO was full
//  `ifdef SYSTOLIC_ROW_TAG_EN: out_row_idx  out  $clog2(N)  row index of out_row
// BEHAVIOUR
//  Reset: FSM=IDLE; counter, FIFO pointers and count, and delay lines cleared. All outputs 0.
//  Input timing: start sampled at cycle t0. Row k, col c is valid on array_out during cycle t0+k+c, for k,c in 0..N-1.
//  De-skew: col c passes through N-1-c registers (col N-1 has none). The delay lines shift every cycle.
//    All cols of row k are aligned at the delay outputs in cycle t0+k+N-1.
//  FSM: IDLE --start--> COLLECT (cnt=0). cnt increments each cycle.
//    COLLECT --cnt==2N-2--> IDLE. start while in COLLECT is ignored; no restart.
//  Write: when cnt in [N-1, 2N-2], the aligned row is pushed with tag k=cnt-(N-1); last=(k==N-1).
//  Read: FWFT FIFO. Row k is visible at out_valid no earlier than cycle t0+k+N.
//    out_row, out_last and tag are held stable while out_valid && !out_ready.
//  Full: a push to a full FIFO is dropped, overflow is set, and stored rows are unaffected.
//    A push and a pop in the same cycle while full are both accepted, since the pop frees the slot first.
//  Empty: out_valid=0, and out_row holds its last value.
//  Pointers wrap modulo FIFO_DEPTH. The count is kept as a separate register so full and empty are unambiguous.
//  start in the cycle COLLECT->IDLE is taken: back-to-back batches run gap-free at one batch per 2N-1 cycles.
//  Reset mid-batch: the partial batch is discarded, FIFO contents are lost and overflow clears. Next valid start begins fresh.
//  Arithmetic: none. Sums pass through bit-exact. The sign bit is preserved, with no extension or truncation.
// CONFIGURATION
//  SYSTOLIC_ROW_TAG_EN defined: the FIFO stores a $clog2(N)-bit row index per entry, driven on out_row_idx.
//    out_row_idx resets to 0.
//  Not defined: no tag storage and no out_row_idx port. out_last still marks the batch end.
// STRUCTURE
//  systolic_pkg: SUM_WIDTH function, FSM state enum {S_IDLE,S_COLLECT}, row-tag width helper.
//    Shared with the array and the feeder.
//  Sub-module skew_delay #(WIDTH, DEPTH): synchronous shift register with reset. DEPTH=0 gives a wire.
//    Instantiated once per column in a generate loop.
//  The FIFO is inline: register array plus rd/wr pointers plus count.
// TESTING (N=4, DATA_WIDTH=4, SUM_WIDTH=16, FIFO_DEPTH=8)
//  1. Single batch, out_ready=1: feed skewed R[k][c]=16*k+c starting at t0.
//     Expect out_row = {k*16+3, k*16+2, k*16+1, k*16+0} at t0+4..t0+7, out_last only on row 3.
//  2. Negative values: R[k][c]=-(k+c+1), e.g. 16'hFFFF.
//     Expect bit-exact rows and busy high for exactly 7 cycles.
//  3. Back-pressure: out_ready=0 across two batches. Expect 8 rows stored and overflow=0.
//     A third batch sets overflow and its rows are dropped. Releasing out_ready yields rows 0-3,0-3 in order.
//  4. Full with simultaneous pop: FIFO at 8 with out_ready=1 during the push cycle.
//     Expect the push accepted and overflow stays 0.
//  5. start pulsed at cnt=3 of an active batch: ignored, and exactly 4 rows result.
//     Back-to-back start at cnt=6: the next batch aligns correctly.
//  6. reset asserted at cnt=4: next cycle out_valid=0, overflow=0, busy=0.
//     A new batch then produces correct rows. With SYSTOLIC_ROW_TAG_EN, out_row_idx=0..3.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared systolic types: collector FSM states, sum width and row-tag width helpers
package systolic_pkg;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_e;

    function automatic int sum_width(input int data_width);
        return data_width * data_width;
    endfunction

    // A one-row array still needs a 1-bit tag so the port never collapses to zero width.
    function automatic int tag_width(input int array_size);
        return (array_size > 1) ? $clog2(array_size) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_collector_skew_delay.sv
// rtl/systolic_result_collector_skew_delay.sv - skew_delay: resettable shift register, DEPTH=0 is a plain wire
module skew_delay #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_reset;
        assign unused_clk_reset = clk ^ reset;
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - de-skews array bottom-edge sums into rows and buffers them in a FWFT FIFO (SYSTOLIC_ROW_TAG_EN adds out_row_idx)
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter int  ARRAY_SIZE = 4,
    parameter int  DATA_WIDTH = 4,
    parameter int  FIFO_DEPTH = 8,
    localparam int SUM_WIDTH  = sum_width(DATA_WIDTH),
    localparam int ROW_WIDTH  = ARRAY_SIZE * SUM_WIDTH,
    localparam int TAG_WIDTH  = tag_width(ARRAY_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROW_WIDTH-1:0] array_out,
    output logic [ROW_WIDTH-1:0] out_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
`ifdef SYSTOLIC_ROW_TAG_EN
    output logic [TAG_WIDTH-1:0] out_row_idx,
`endif
    output logic                 busy,
    output logic                 overflow
);

    localparam int CNT_W    = $clog2(2 * ARRAY_SIZE - 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_FW   = PTR_W + 1;
    localparam int WR_FIRST = ARRAY_SIZE - 2;
    localparam int WR_LAST  = 2 * ARRAY_SIZE - 3;

    localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(2 * ARRAY_SIZE - 2);
    localparam logic [CNT_FW-1:0] FIFO_FULL = CNT_FW'(FIFO_DEPTH);

    // ---------------- de-skew ----------------
    logic [ROW_WIDTH-1:0] aligned_row;

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
        skew_delay #(
            .WIDTH (SUM_WIDTH),
            .DEPTH (ARRAY_SIZE - 1 - c)
        ) u_skew (
            .clk   (clk),
            .reset (reset),
            .din   (array_out[c*SUM_WIDTH +: SUM_WIDTH]),
            .dout  (aligned_row[c*SUM_WIDTH +: SUM_WIDTH])
        );
    end

    // ---------------- control FSM ----------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;
    logic             wr_last;
`ifdef SYSTOLIC_ROW_TAG_EN
    logic [TAG_WIDTH-1:0] wr_tag;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start arriving in the final COLLECT cycle re-enters COLLECT directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (cnt_q == CNT_END) begin
                    state_d = start ? S_COLLECT : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // cnt_q counts from the cycle after start, so row k is aligned while cnt_q == k+N-2.
    always_comb begin
        busy    = (state_q == S_COLLECT);
        wr_en   = busy && (cnt_q >= CNT_W'(WR_FIRST)) && (cnt_q <= CNT_W'(WR_LAST));
        wr_last = busy && (cnt_q == CNT_W'(WR_LAST));
`ifdef SYSTOLIC_ROW_TAG_EN
        wr_tag  = TAG_WIDTH'(cnt_q - CNT_W'(WR_FIRST));
`endif
    end

    // ---------------- result FIFO ----------------
    logic [ROW_WIDTH-1:0]  mem_row_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]     count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [ROW_WIDTH-1:0]  head_row_q, head_row_d;
    logic                  head_last_q, head_last_d;
    logic                  push, pop;
`ifdef SYSTOLIC_ROW_TAG_EN
    logic [TAG_WIDTH-1:0]  mem_tag_q [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  head_tag_q, head_tag_d;
`endif

    always_comb begin
        pop        = (count_q != '0) && out_ready;
        push       = wr_en && ((count_q != FIFO_FULL) || pop);
        overflow_d = overflow_q | (wr_en & ~push);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_FW'(push) - CNT_FW'(pop);

        // The head register presents the next FIFO front; it holds while empty.
        head_row_d  = head_row_q;
        head_last_d = head_last_q;
`ifdef SYSTOLIC_ROW_TAG_EN
        head_tag_d  = head_tag_q;
`endif
        if (push && count_d == CNT_FW'(1)) begin
            head_row_d  = aligned_row;
            head_last_d = wr_last;
`ifdef SYSTOLIC_ROW_TAG_EN
            head_tag_d  = wr_tag;
`endif
        end else if (count_d != '0) begin
            head_row_d  = mem_row_q[rd_ptr_d];
            head_last_d = mem_last_q[rd_ptr_d];
`ifdef SYSTOLIC_ROW_TAG_EN
            head_tag_d  = mem_tag_q[rd_ptr_d];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            head_row_q  <= '0;
            head_last_q <= 1'b0;
`ifdef SYSTOLIC_ROW_TAG_EN
            head_tag_q  <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            head_row_q  <= head_row_d;
            head_last_q <= head_last_d;
`ifdef SYSTOLIC_ROW_TAG_EN
            head_tag_q  <= head_tag_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_row_q[wr_ptr_q]  <= aligned_row;
            mem_last_q[wr_ptr_q] <= wr_last;
`ifdef SYSTOLIC_ROW_TAG_EN
            mem_tag_q[wr_ptr_q]  <= wr_tag;
`endif
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_row     = head_row_q;
    assign out_last    = head_last_q & out_valid;
    assign overflow    = overflow_q;
`ifdef SYSTOLIC_ROW_TAG_EN
    assign out_row_idx = head_tag_q;
`endif

endmodule
